// File: rtl/cache_line.sv
// One way's cache line: WORDS x WORD_W data words plus tag, valid and dirty.
// Serves CPU word accesses in IDLE and runs burst fill / burst write-back.
module cache_line #(
   parameter int WORD_W = 16,
   parameter int WORDS  = 4,
   parameter int TAG_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     write,
   input  logic [$clog2(WORDS)-1:0] word_sel,
   input  logic [TAG_W-1:0]         tag_in,
   input  logic [WORD_W-1:0]        data_in,
   output logic [WORD_W-1:0]        data_out,
   output logic                     hit,
   output logic                     valid,
   output logic                     dirty,
   output logic [TAG_W-1:0]         tag_out,
   output logic                     busy,
   input  logic                     fill_start,
   input  logic                     fill_valid,
   input  logic [WORD_W-1:0]        fill_data,
   input  logic                     wb_start,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [WORD_W-1:0]        wb_data,
   output logic                     wb_last
);
   localparam int CW = $clog2(WORDS);
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WB} state_t;

   state_t                        state_q, state_d;
   logic [WORDS-1:0][WORD_W-1:0]  mem;
   logic [CW-1:0]                 cnt;
   logic                          wb_go, fill_go, rd_go, wr_go, fill_beat, wb_beat;

   assign hit      = valid && (tag_in == tag_out);
   assign busy     = (state_q != IDLE);
   assign wb_valid = (state_q == WB);
   assign wb_data  = mem[cnt];
   assign wb_last  = (state_q == WB) && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // IDLE priority: write-back (only if there is dirty data), then fill, then CPU.
   always_comb begin
      state_d   = state_q;
      wb_go     = 1'b0;
      fill_go   = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      fill_beat = 1'b0;
      wb_beat   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_start && valid && dirty) begin
               wb_go   = 1'b1;
               state_d = WB;
            end else if (fill_start) begin
               fill_go = 1'b1;
               state_d = FILL;
            end else if (enable) begin
               rd_go = !write;
               wr_go = write && hit;
            end
         end
         FILL: begin
            fill_beat = fill_valid;
            if (fill_valid && cnt == LAST) state_d = IDLE;
         end
         WB: begin
            wb_beat = wb_ready;
            if (wb_ready && cnt == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid    <= 1'b0;
         dirty    <= 1'b0;
         tag_out  <= '0;
         data_out <= '0;
         cnt      <= '0;
      end else begin
         if (wb_go) cnt <= '0;
         if (fill_go) begin
            tag_out <= tag_in;
            valid   <= 1'b0;
            dirty   <= 1'b0;
            cnt     <= '0;
         end
         if (rd_go) data_out <= mem[word_sel];
         if (wr_go) dirty <= 1'b1;
         if (fill_beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) valid <= 1'b1;
         end
         if (wb_beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) dirty <= 1'b0;
         end
      end
   end

   // Data words carry no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (wr_go)          mem[word_sel] <= data_in;
      else if (fill_beat) mem[cnt]      <= fill_data;
   end
endmodule

// File: tb/tb_cache_line.sv
// Scoreboard bench for cache_line: driver updates a word-array model and queues
// expected read/write-back data; a monitor pops and compares on DUT output events.
module tb_cache_line;
   localparam int WORD_W = 16;
   localparam int WORDS  = 4;
   localparam int TAG_W  = 8;

   logic              clk = 1'b0;
   logic              reset, enable, write, fill_start, fill_valid, wb_start, wb_ready;
   logic [1:0]        word_sel;
   logic [TAG_W-1:0]  tag_in, tag_out;
   logic [WORD_W-1:0] data_in, fill_data, data_out, wb_data;
   logic              hit, valid, dirty, busy, wb_valid, wb_last;

   typedef struct packed {logic [WORD_W-1:0] d; logic last;} beat_t;

   logic [WORD_W-1:0] rd_q[$];
   beat_t             wb_q[$];
   int                vectors = 0, fails = 0;

   logic [WORD_W-1:0] ref_mem [WORDS];
   logic [WORD_W-1:0] fill_buf [WORDS];
   logic [TAG_W-1:0]  ref_tag;
   logic              ref_valid, ref_dirty;
   logic [WORD_W-1:0] ref_dout;

   cache_line #(.WORD_W(WORD_W), .WORDS(WORDS), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .write(write), .word_sel(word_sel),
      .tag_in(tag_in), .data_in(data_in), .data_out(data_out), .hit(hit), .valid(valid),
      .dirty(dirty), .tag_out(tag_out), .busy(busy), .fill_start(fill_start),
      .fill_valid(fill_valid), .fill_data(fill_data), .wb_start(wb_start),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: decides at the edge whether a read or a write-back beat happened.
   initial begin
      logic rf, wf;
      beat_t b, e;
      forever begin
         @(posedge clk);
         rf = !reset && enable && !write && !busy && !fill_start && !(wb_start && valid && dirty);
         wf = !reset && wb_valid && wb_ready;
         b.d = wb_data;
         b.last = wb_last;
         #1;
         if (rf) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", data_out, rd_q.pop_front());
         end
         if (wf) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
               e = wb_q.pop_front();
               chk("wb_beat_data", b.d, e.d);
               chk("wb_beat_last", b.last, e.last);
            end
         end
      end
   end

   task automatic do_read(input logic [1:0] ws, input logic [TAG_W-1:0] tg);
      enable = 1'b1; write = 1'b0; word_sel = ws; tag_in = tg;
      rd_q.push_back(ref_mem[ws]);
      ref_dout = ref_mem[ws];
      #1 chk("rd_hit", hit, ref_valid && tg == ref_tag);
      tick;
      enable = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] ws, input logic [TAG_W-1:0] tg, input logic [WORD_W-1:0] d);
      logic h;
      h = ref_valid && tg == ref_tag;
      enable = 1'b1; write = 1'b1; word_sel = ws; tag_in = tg; data_in = d;
      #1 chk("wr_hit", hit, h);
      tick;
      enable = 1'b0; write = 1'b0;
      if (h) begin
         ref_mem[ws] = d;
         ref_dirty = 1'b1;
      end
      chk("wr_dirty", dirty, ref_dirty);
   endtask

   // gap_mask[i] inserts an idle cycle before beat i; poke drives a CPU read in that gap.
   task automatic do_fill(input logic [TAG_W-1:0] tg, input logic [3:0] gap_mask, input bit poke);
      int nb;
      nb = 0;
      fill_start = 1'b1; tag_in = tg;
      tick;
      fill_start = 1'b0;
      ref_tag = tg; ref_valid = 1'b0; ref_dirty = 1'b0;
      chk("fill_valid_low", valid, 0);
      for (int i = 0; i < WORDS; i++) begin
         if (gap_mask[i]) begin
            nb += int'(busy);
            if (poke && i == 0) begin
               enable = 1'b1; write = 1'b0; word_sel = 2'($urandom_range(0, 3));
            end
            tick;
            enable = 1'b0;
            if (poke && i == 0) chk("busy_read_ignored", data_out, ref_dout);
         end
         nb += int'(busy);
         fill_valid = 1'b1; fill_data = fill_buf[i];
         tick;
         fill_valid = 1'b0;
         ref_mem[i] = fill_buf[i];
      end
      ref_valid = 1'b1;
      chk("fill_busy_cycles", nb, WORDS + $countones(gap_mask));
      chk("fill_done_busy", busy, 0);
      chk("fill_done_valid", valid, 1);
      chk("fill_tag", tag_out, tg);
   endtask

   task automatic do_wb(input logic [7:0] rpat, input bit use_pat, input bit also_fill);
      int beat, cyc;
      bit go;
      beat_t e;
      go = ref_valid && ref_dirty;
      wb_start = 1'b1; fill_start = also_fill; tag_in = 8'hA5;
      tick;
      wb_start = 1'b0; fill_start = 1'b0;
      if (!go) begin
         chk("wb_ignored", busy, 0);
         return;
      end
      chk("wb_entered", wb_valid, 1);
      chk("wb_tag_kept", tag_out, ref_tag);
      for (int i = 0; i < WORDS; i++) begin
         e.d = ref_mem[i];
         e.last = (i == WORDS - 1);
         wb_q.push_back(e);
      end
      beat = 0; cyc = 0;
      while (beat < WORDS && cyc < 60) begin
         wb_ready = use_pat ? rpat[cyc % 8] : 1'($urandom_range(0, 1));
         #1;
         chk("wb_hold_data", wb_data, ref_mem[beat]);
         chk("wb_hold_last", wb_last, beat == WORDS - 1);
         if (wb_ready) beat++;
         tick;
         cyc++;
      end
      wb_ready = 1'b0;
      if (cyc >= 60) chk("wb_timeout", 1, 0);
      ref_dirty = 1'b0;
      chk("wb_done_busy", busy, 0);
      chk("wb_done_dirty", dirty, 0);
      chk("wb_done_valid", valid, 1);
   endtask

   initial begin
      reset = 1'b1; enable = 0; write = 0; fill_start = 0; fill_valid = 0; wb_start = 0;
      wb_ready = 0; word_sel = 0; tag_in = 0; data_in = 0; fill_data = 0;
      ref_tag = 0; ref_valid = 0; ref_dirty = 0; ref_dout = 0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 'x;
      tick; tick;
      reset = 1'b0;

      // 1: reset state
      chk("rst_valid", valid, 0); chk("rst_dirty", dirty, 0);
      chk("rst_busy", busy, 0);   chk("rst_dout", data_out, 0);
      for (int t = 0; t < 4; t++) begin
         tag_in = 8'(t * 85);
         #1 chk("rst_hit", hit, 0);
         chk("rst_wb_valid", wb_valid, 0);
      end

      // 2: fill with one gap, then read word 2
      fill_buf = '{16'h0F0F, 16'h1111, 16'h2222, 16'h3333};
      do_fill(8'h3C, 4'b0010, 0);
      do_read(2'd2, 8'h3C);

      // 3: write hit then miss
      do_write(2'd1, 8'h3C, 16'hBEEF);
      do_read(2'd1, 8'h3C);
      do_write(2'd1, 8'h3D, 16'h1234);
      do_read(2'd1, 8'h3C);

      // 4: write-back with ready 1,0,1,1,0,1
      do_wb(8'b0010_1101, 1, 0);

      // 5: priority and ignore cases
      do_write(2'd3, 8'h3C, 16'hCAFE);
      do_wb(8'hFF, 0, 1);
      do_wb(8'hFF, 0, 0);
      do_read(2'd0, 8'h3C);
      fill_buf = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
      do_fill(8'h3C, 4'b0001, 1);

      // 6: reset after two fill beats, then refill from word 0
      fill_start = 1'b1; tag_in = 8'h55; tick; fill_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fill_valid = 1'b1; fill_data = 16'h5500 + 16'(i); tick; fill_valid = 1'b0;
         ref_mem[i] = 16'h5500 + 16'(i);
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", valid, 0); chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dirty", dirty, 0); chk("mid_rst_wb_valid", wb_valid, 0);
      ref_valid = 0; ref_dirty = 0; ref_tag = 0; ref_dout = 0;
      tick;
      reset = 1'b0;
      fill_buf = '{16'h6060, 16'h6161, 16'h6262, 16'h6363};
      do_fill(8'h66, 4'b0000, 0);
      do_read(2'd0, 8'h66);
      do_read(2'd3, 8'h66);

      // random traffic against the model
      for (int n = 0; n < 150; n++) begin
         logic [TAG_W-1:0] tg;
         tg = ($urandom_range(0, 2) != 0) ? ref_tag : 8'($urandom);
         case ($urandom_range(0, 9))
            0: begin
               for (int i = 0; i < WORDS; i++) fill_buf[i] = 16'($urandom);
               do_fill(tg, 4'($urandom), 0);
            end
            1, 2:    do_wb(8'h00, 0, 0);
            3, 4, 5: do_read(2'($urandom_range(0, 3)), tg);
            default: do_write(2'($urandom_range(0, 3)), tg, 16'($urandom));
         endcase
      end

      tick; tick;
      chk("rd_q_drained", rd_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
